hamming74_rx: RTL and testbench

Serial receive-side stage for the Hamming(7,4) link. It deserializes 7-bit codewords arriving one bit per cycle, computes the syndrome, and corrects any single-bit error. It delivers the 4-bit info word through a one-entry valid/ready output buffer, and tracks corrected errors and overflow. It sits directly downstream of the Hamming(7,4) encoder plus channel and consumes the encoder's codeword layout.

---
 rtl/hamming74_pkg.sv | 23 ++
 rtl/hm_dec.sv | 25 ++
 rtl/hamming74_rx.sv | 143 ++++++++++++++
 tb/tb_hamming74_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) types, rx FSM states and codeword bit positions
// (position k of the code lives at bit k-1 of codeword_t).
package hamming74_pkg;

  typedef logic [6:0] codeword_t;
  typedef logic [3:0] info_t;
  typedef logic [2:0] synd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P3_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

endpackage

// File: rtl/hm_dec.sv
// Combinational Hamming(7,4) decoder: syndrome, single-bit correction and
// extraction of the info word {d3,d2,d1,d0}.
module hm_dec
  import hamming74_pkg::*;
(
  input  codeword_t cw,
  output synd_t     synd,
  output info_t     info,
  output logic      corr
);

  codeword_t fixed;

  always_comb begin
    synd[0] = cw[P1_POS] ^ cw[D0_POS] ^ cw[D1_POS] ^ cw[D3_POS];
    synd[1] = cw[P2_POS] ^ cw[D0_POS] ^ cw[D2_POS] ^ cw[D3_POS];
    synd[2] = cw[P3_POS] ^ cw[D1_POS] ^ cw[D2_POS] ^ cw[D3_POS];
    fixed = cw;
    // A nonzero syndrome is the 1-based position of the bit to flip.
    if (synd != '0) fixed[synd - 3'd1] = ~cw[synd - 3'd1];
    corr = (synd != '0);
    info = {fixed[D3_POS], fixed[D2_POS], fixed[D1_POS], fixed[D0_POS]};
  end

endmodule

// File: rtl/hamming74_rx.sv
// Serial Hamming(7,4) receiver with one-entry valid/ready output buffer.
// Define HAMMING74_RX_ERRCNT_EN to build the saturating corrected-error counter.
module hamming74_rx
  import hamming74_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic             sof,
  output logic [3:0]       dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             corr,
  output logic [2:0]       synd,
  output logic             ovf,
  input  logic             clr,
  output logic [CNT_W-1:0] err_cnt
);

  rx_state_t state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       wr;
  logic [2:0] wr_idx;
  codeword_t  cw;
  synd_t      dec_synd;
  info_t      dec_info;
  logic       dec_corr;
  logic       done, load, drop;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr        = 1'b0;
    wr_idx    = idx;
    case (state)
      IDLE: begin
        if (bit_vld && sof) begin
          wr        = 1'b1;
          wr_idx    = 3'd0;
          idx_nxt   = 3'd1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_vld) begin
          wr = 1'b1;
          // A new sof restarts the frame; the partial word is silently lost.
          if (sof) begin
            wr_idx  = 3'd0;
            idx_nxt = 3'd1;
          end else if (idx == 3'd6) begin
            idx_nxt   = 3'd0;
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      DONE: begin
        if (bit_vld && sof) begin
          wr        = 1'b1;
          wr_idx    = 3'd0;
          idx_nxt   = 3'd1;
          state_nxt = SHIFT;
        end else begin
          idx_nxt   = 3'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        idx_nxt   = 3'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Decode reads cw during DONE while c0 of the next frame may overwrite bit 0.
  always_ff @(posedge clk) begin
    if (wr) cw[wr_idx] <= bit_in;
  end

  hm_dec u_dec (
    .cw   (cw),
    .synd (dec_synd),
    .info (dec_info),
    .corr (dec_corr)
  );

  assign done = (state == DONE);
  assign load = done && (!dout_vld || dout_rdy);
  assign drop = done && dout_vld && !dout_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      corr     <= 1'b0;
      synd     <= '0;
    end else if (load) begin
      dout     <= dec_info;
      dout_vld <= 1'b1;
      corr     <= dec_corr;
      synd     <= dec_synd;
    end else if (dout_rdy) begin
      dout_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (clr)  ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

`ifdef HAMMING74_RX_ERRCNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Dropped words still count: the error happened on the link regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_cnt <= '0;
    else if (clr)              err_cnt <= '0;
    else if (done && dec_corr) err_cnt <= sat_inc(err_cnt);
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming74_rx.sv
// Scoreboard bench for hamming74_rx: expected words queued at stimulus time,
// a buffer/flag model consumes them and every output is compared each cycle.
module tb_hamming74_rx;

  localparam int CNT_W = 2;
`ifdef HAMMING74_RX_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic bit_vld = 1'b0, bit_in = 1'b0, sof = 1'b0, dout_rdy = 1'b0, clr = 1'b0;
  logic [3:0] dout;
  logic dout_vld, corr, ovf;
  logic [2:0] synd;
  logic [CNT_W-1:0] err_cnt;

  hamming74_rx #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld), .bit_in(bit_in), .sof(sof),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .corr(corr),
    .synd(synd), .ovf(ovf), .clr(clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] info;
    logic [2:0] synd;
    logic       corr;
    int         load_edge;
  } exp_t;

  exp_t exp_q[$];
  int ecount = 0;
  int compared = 0;
  int mismatched = 0;
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random per cycle

  logic       m_vld = 1'b0, m_corr = 1'b0, m_ovf = 1'b0;
  logic [3:0] m_dout = '0;
  logic [2:0] m_synd = '0;
  int         m_cnt = 0;

  // Syndrome as the XOR of the 1-based positions of all set bits.
  function automatic exp_t ref_decode(input logic [6:0] cw);
    exp_t e;
    int s = 0;
    logic [6:0] f;
    for (int k = 1; k <= 7; k++) if (cw[k-1]) s = s ^ k;
    f = cw;
    if (s != 0) f[s-1] = ~f[s-1];
    e.info = {f[6], f[5], f[4], f[2]};
    e.synd = s[2:0];
    e.corr = (s != 0);
    e.load_edge = 0;
    return e;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Reference model of the output buffer, ovf and counter, advanced per edge.
  initial forever begin
    @(posedge clk);
    ecount++;
    if (!rst_n) begin
      m_vld = 1'b0; m_dout = '0; m_corr = 1'b0; m_synd = '0; m_ovf = 1'b0; m_cnt = 0;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].load_edge == ecount) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.corr && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_vld || dout_rdy) begin
          m_vld = 1'b1; m_dout = e.info; m_corr = e.corr; m_synd = e.synd;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_vld && dout_rdy) begin
        m_vld = 1'b0;
      end
      if (clr) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
    end
  end

  // Monitor: compare every output on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_dout_vld", dout_vld, 0);
      check("rst_dout", dout, 0);
      check("rst_corr", corr, 0);
      check("rst_synd", synd, 0);
      check("rst_ovf", ovf, 0);
      check("rst_err_cnt", err_cnt, 0);
    end else begin
      check("dout_vld", dout_vld, m_vld);
      check("dout", dout, m_dout);
      check("corr", corr, m_corr);
      check("synd", synd, m_synd);
      check("ovf", ovf, m_ovf);
      check("err_cnt", err_cnt, ERRCNT_ON ? m_cnt : 0);
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: dout_rdy = 1'b0;
      1: dout_rdy = 1'b1;
      default: dout_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    bit_vld = 1'b0;
    sof = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [6:0] cw, input int nbits, input int max_gap,
                           input bit full, input bit clr_done);
    for (int i = 0; i < nbits; i++) begin
      if (max_gap > 0 && i > 0) idle($urandom_range(0, max_gap));
      bit_vld = 1'b1;
      sof = (i == 0);
      bit_in = cw[i];
      if (full && i == 6) begin
        exp_t e;
        e = ref_decode(cw);
        e.load_edge = ecount + 2;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    bit_vld = 1'b0;
    sof = 1'b0;
    if (clr_done) begin
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [6:0] cw, input int max_gap, input bit clr_done);
    send_bits(cw, 7, max_gap, 1'b1, clr_done);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    logic [6:0] cw;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Clean 7'h55 and a c4-flipped copy, consumer always ready.
    rdy_mode = 1;
    send_frame(7'h55, 0, 1'b0);
    idle(4);
    send_frame(7'b1000101, 0, 1'b0);
    idle(4);

    // Consumer stalled: second word dropped, then a single pop and clr.
    rdy_mode = 0;
    send_frame(encode(4'hB), 0, 1'b0);
    idle(1);
    send_frame(encode(4'h3), 0, 1'b0);
    idle(3);
    rdy_mode = 1;
    idle(1);
    rdy_mode = 0;
    idle(3);
    pulse_clr();
    idle(2);

    // Aborted partial frame followed by a full one.
    rdy_mode = 1;
    send_bits(7'h2A, 3, 0, 1'b0, 1'b0);
    send_frame(7'h55, 0, 1'b0);
    idle(4);

    // Reset in the middle of a frame.
    send_bits(7'h33, 4, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    send_frame(7'h55, 0, 1'b0);
    idle(4);

    // Counter saturation, then clr coinciding with an errored DONE.
    pulse_clr();
    for (int n = 0; n < 5; n++) begin
      cw = encode(4'($urandom_range(0, 15)));
      cw[$urandom_range(0, 6)] ^= 1'b1;
      send_frame(cw, 0, 1'b0);
      idle(1);
    end
    cw = encode(4'h9);
    cw[2] ^= 1'b1;
    send_frame(cw, 0, 1'b1);
    idle(3);

    // Randomized traffic: back-to-back, gaps, aborts, noise, clr, random ready.
    rdy_mode = 2;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_bits(7'($urandom), $urandom_range(1, 6), 1, 1'b0, 1'b0);
        send_frame(7'($urandom), 1, 1'b0);
      end else if (r == 1) begin
        repeat ($urandom_range(1, 3)) begin
          bit_vld = 1'b1;
          sof = 1'b0;
          bit_in = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        bit_vld = 1'b0;
      end else if (r == 2) begin
        pulse_clr();
      end else if (r < 5) begin
        send_frame(7'($urandom), $urandom_range(0, 2), 1'b0);
      end else begin
        cw = encode(4'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 1) cw[$urandom_range(0, 6)] ^= 1'b1;
        send_frame(cw, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      end
      idle($urandom_range(0, 2));
    end

    rdy_mode = 1;
    idle(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
